rcn_slave: RTL and testbench
============================

RCN_SLAVE -- requirements
Module: rcn_slave

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 22'h000000, byte base address this slave decodes.
REQ-002 SHALL have parameter ADDR_MASK, default 22'h3F0000, address bits compared against ADDR_BASE.
REQ-003 SHALL have parameter TIMEOUT, default 16, cycles cs may wait for ack (range 1..255).
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: rcn_in input 67 ring in; rcn_out output 67 ring out.
REQ-006 SHALL have ports: cs output 1 local access strobe; wr output 1 write; mask output 4 byte enables; addr output 22 byte address; wdata output 32 write data.
REQ-007 SHALL have ports: ack input 1 local access done; rdata input 32 read data; timeout output 1 abort pulse.

Function
REQ-008 Ring word format SHALL be {valid[66], pending[65], wr[64], id[63:58], seq[57:56], we[55:52], addr[51:32] (byte addr bits 21:2), data[31:0]}.
REQ-009 rcn_in SHALL be registered into rin every cycle; rcn_out SHALL be driven only from register rout.
REQ-010 A request SHALL be "mine" when rin valid=1, pending=1, and ({rin[51:32],2'b00} & ADDR_MASK) == (ADDR_BASE & ADDR_MASK).
REQ-011 FSM SHALL have states IDLE, REQ, RSP; reset state IDLE.
REQ-012 IDLE with a mine request: capture rin into the hold register, set rout to 67'd0 (slot freed), go to REQ.
REQ-013 In every other case not covered by REQ-012/REQ-015, rout SHALL be loaded with rin unchanged (pass-through), including mine requests arriving in REQ or RSP.
REQ-014 REQ: cs=1 and wr/mask/addr/wdata SHALL reflect the held request, addr = {held addr,2'b00}; on ack=1, capture rdata (read) or keep held data (write), go to RSP; ack in the first REQ cycle SHALL be honored.
REQ-015 RSP: when rin valid=0, load rout with {1,0,held wr,id,seq,we,addr,data} and go to IDLE; otherwise pass rin and stay in RSP.
REQ-016 The response data field SHALL be the captured rdata for reads and the held wdata for writes.
REQ-017 cs, wr, mask, addr, wdata SHALL be 0 outside REQ; ack outside REQ SHALL be ignored.
REQ-018 Zero-wait latency: request on rcn_in in cycle 0, cs=1 in cycle 2, ack=1 in cycle 2 and rin empty in cycle 3 -> response on rcn_out in cycle 4.
REQ-019 A new request SHALL NOT be accepted in the cycle the response is inserted; acceptance resumes from IDLE the next cycle.

Reset
REQ-020 rst SHALL asynchronously clear rin, rout, hold register, timeout counter, state to IDLE; cs, timeout and rcn_out SHALL be 0 during and after reset.
REQ-021 Reset during REQ or RSP SHALL drop the held request without emitting a response.

Configuration
REQ-022 With macro RCN_SLAVE_TIMEOUT_EN defined: an 8-bit counter SHALL count REQ cycles; if ack=0 for TIMEOUT consecutive REQ cycles, go to RSP with data 32'hDEADDEAD and pulse timeout for one cycle.
REQ-023 Without RCN_SLAVE_TIMEOUT_EN: REQ SHALL wait for ack indefinitely, timeout tied 0, no counter.

Verification
REQ-024 Read, ADDR_BASE=22'h010000, request id=5 seq=2 addr=22'h010010 we=4'hF, ack in first REQ cycle with rdata=32'h12345678 -> rcn_out cycle 4 = {1,0,0,5,2,F,20'h04004,32'h12345678}, cs high exactly 1 cycle.
REQ-025 Write addr=22'h010004 mask=4'h3 wdata=32'hA5A5A5A5, ack after 3 wait cycles -> cs high 4 cycles with wr=1 mask=3 addr=22'h010004; response wr=1 data=32'hA5A5A5A5, pending=0.
REQ-026 Request to addr=22'h020000 -> passes to rcn_out unchanged one cycle later, cs stays 0.
REQ-027 Two back-to-back mine requests -> first consumed (rcn_out slot 0), second passed through unchanged; continuous valid traffic during RSP delays response until first empty slot.
REQ-028 With RCN_SLAVE_TIMEOUT_EN, TIMEOUT=16, ack held 0 -> timeout pulse after 16 REQ cycles, response data 32'hDEADDEAD; rst asserted mid-REQ -> no response emitted, cs=0 immediately.

Source files
------------

// File: rtl/rcn_slave.sv
// rcn_slave: ring-network slave endpoint.
// Watches the 67-bit ring for requests addressed to this slave, frees the
// slot, runs a local cs/ack access, then reinserts the response into the
// first empty ring slot. All other ring traffic is passed through with a
// single register of latency.
// Optional feature: define RCN_SLAVE_TIMEOUT_EN to abort a local access that
// has not been acknowledged within TIMEOUT cycles (response data 32'hDEADDEAD
// plus a one-cycle timeout pulse). Without it the slave waits for ack forever.
module rcn_slave #(
  parameter logic [21:0] ADDR_BASE = 22'h000000,
  parameter logic [21:0] ADDR_MASK = 22'h3F0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [66:0] rcn_in,
  output logic [66:0] rcn_out,
  output logic        cs,
  output logic        wr,
  output logic [3:0]  mask,
  output logic [21:0] addr,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic [31:0] rdata,
  output logic        timeout
);

  // TIMEOUT must fit the 8-bit wait counter and be at least one cycle.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rcn_slave: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t      r_state;
  logic [66:0] r_rin;
  logic [66:0] r_rout;
  // Held request minus valid/pending: {wr, id, seq, we, addr, data}.
  logic [64:0] r_hold;
  logic        r_cs;
  logic        w_mine;

`ifdef RCN_SLAVE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt;
  logic       r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  // A valid, still-pending request whose byte address falls in our window.
  assign w_mine = r_rin[66] & r_rin[65] &
                  (({r_rin[51:32], 2'b00} & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

  assign rcn_out = r_rout;
  assign cs      = r_cs;
  assign wr      = r_cs & r_hold[64];
  assign mask    = r_cs ? r_hold[55:52] : 4'h0;
  assign addr    = r_cs ? {r_hold[51:32], 2'b00} : 22'h0;
  assign wdata   = r_cs ? r_hold[31:0] : 32'h0;

  // Ring input register: every ring word is sampled once before any decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rin <= '0;
    end else begin
      r_rin <= rcn_in;
    end
  end

  // Request/response FSM; rout defaults to pass-through of the sampled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rout    <= '0;
      r_hold    <= '0;
      r_cs      <= 1'b0;
`ifdef RCN_SLAVE_TIMEOUT_EN
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_rout <= r_rin;
`ifdef RCN_SLAVE_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_mine) begin
            // Consume the request: hold it and free its ring slot.
            r_hold  <= r_rin[64:0];
            r_rout  <= '0;
            r_cs    <= 1'b1;
            r_state <= REQ;
`ifdef RCN_SLAVE_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
          end
        end
        REQ: begin
          if (ack) begin
            // Reads return local data; writes echo the held write data.
            if (!r_hold[64]) begin
              r_hold[31:0] <= rdata;
            end
            r_cs    <= 1'b0;
            r_state <= RSP;
          end
`ifdef RCN_SLAVE_TIMEOUT_EN
          else if (r_cnt == TMO_LAST) begin
            r_hold[31:0] <= 32'hDEADDEAD;
            r_cs         <= 1'b0;
            r_timeout    <= 1'b1;
            r_state      <= RSP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        RSP: begin
          // Response waits for the first empty slot on the ring.
          if (!r_rin[66]) begin
            r_rout  <= {2'b10, r_hold};
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcn_slave.sv
// Testbench for rcn_slave: directed scenarios with literal expectations plus
// randomized ring traffic checked every cycle against a transaction-level model.
module tb_rcn_slave;

  localparam logic [21:0] BASE = 22'h010000;
  localparam logic [21:0] AMSK = 22'h3F0000;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [66:0] rcn_in = '0;
  logic [66:0] rcn_out;
  logic        cs, wr, timeout;
  logic [3:0]  mask;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  rcn_slave #(.ADDR_BASE(BASE), .ADDR_MASK(AMSK), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rcn_in(rcn_in), .rcn_out(rcn_out),
    .cs(cs), .wr(wr), .mask(mask), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] mk(logic v, logic p, logic w, logic [5:0] id,
                                     logic [1:0] sq, logic [3:0] we,
                                     logic [21:0] a, logic [31:0] d);
    return {v, p, w, id, sq, we, a[21:2], d};
  endfunction

  function automatic bit is_mine(logic [66:0] x);
    return x[66] && x[65] && ((({x[51:32], 2'b00}) & AMSK) == (BASE & AMSK));
  endfunction

  task automatic chk(string nm, logic [66:0] act, logic [66:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Slave is either free, busy with a local access (waiting for ack), or
  // holding a finished response waiting for an empty ring slot.
  logic [66:0] m_rin, m_out, m_held;
  bit          m_busy, m_done, m_tmo;
  int          m_wait;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rin = '0; m_out = '0; m_held = '0;
      m_busy = 0; m_done = 0; m_tmo = 0; m_wait = 0;
    end else begin
      m_tmo = 0;
      m_out = m_rin;
      if (!m_busy) begin
        if (is_mine(m_rin)) begin
          m_held = m_rin; m_out = '0; m_busy = 1; m_done = 0; m_wait = 0;
        end
      end else if (!m_done) begin
        if (ack) begin
          m_done = 1;
          if (!m_held[64]) m_held[31:0] = rdata;
        end
`ifdef RCN_SLAVE_TIMEOUT_EN
        else begin
          m_wait = m_wait + 1;
          if (m_wait == TMO) begin
            m_done = 1; m_held[31:0] = 32'hDEADDEAD; m_tmo = 1;
          end
        end
`endif
      end else if (!m_rin[66]) begin
        m_out  = {2'b10, m_held[64:0]};
        m_busy = 0;
      end
      m_rin = rcn_in;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit e_cs;
    e_cs = m_busy && !m_done;
    chk("m_rcn_out", rcn_out, m_out);
    chk("m_cs",      67'(cs),      67'(e_cs));
    chk("m_wr",      67'(wr),      67'(e_cs && m_held[64]));
    chk("m_mask",    67'(mask),    e_cs ? 67'(m_held[55:52]) : 67'd0);
    chk("m_addr",    67'(addr),    e_cs ? 67'({m_held[51:32], 2'b00}) : 67'd0);
    chk("m_wdata",   67'(wdata),   e_cs ? 67'(m_held[31:0]) : 67'd0);
    chk("m_timeout", 67'(timeout), 67'(m_tmo));
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(string nm);
    int k;
    k = 0;
    while (!rcn_out[66] && k < 40) begin
      step(1);
      k++;
    end
    if (!rcn_out[66]) chk({nm, "_no_response"}, 67'd0, 67'd1);
  endtask

  initial begin
    logic [66:0] w, a, b, n1, n2, n3;
    int k;

    // Reset state
    rst = 1'b1;
    step(3);
    chk("rst_cs", 67'(cs), 67'd0);
    chk("rst_rcn_out", rcn_out, 67'd0);
    chk("rst_timeout", 67'(timeout), 67'd0);
    rst = 1'b0;
    step(2);

    // Zero-wait read: response in cycle 4
    rcn_in = mk(1, 1, 0, 6'd5, 2'd2, 4'hF, 22'h010010, 32'h0);
    step(1);
    rcn_in = '0;
    step(1);
    chk("rd_cs_c2", 67'(cs), 67'd1);
    chk("rd_addr_c2", 67'(addr), 67'(22'h010010));
    chk("rd_wr_c2", 67'(wr), 67'd0);
    chk("rd_slot_freed", rcn_out, 67'd0);
    ack = 1'b1; rdata = 32'h12345678;
    step(1);
    ack = 1'b0; rdata = $urandom;
    chk("rd_cs_c3", 67'(cs), 67'd0);
    step(1);
    chk("rd_rsp_c4", rcn_out, {1'b1, 1'b0, 1'b0, 6'd5, 2'd2, 4'hF, 20'h04004, 32'h12345678});
    step(3);

    // Write with three wait cycles
    rcn_in = mk(1, 1, 1, 6'd9, 2'd1, 4'h3, 22'h010004, 32'hA5A5A5A5);
    step(1);
    rcn_in = '0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk("wr_cs", 67'(cs), 67'd1);
      chk("wr_wr", 67'(wr), 67'd1);
      chk("wr_mask", 67'(mask), 67'h3);
      chk("wr_addr", 67'(addr), 67'(22'h010004));
      chk("wr_wdata", 67'(wdata), 67'(32'hA5A5A5A5));
      if (i == 3) ack = 1'b1;
      step(1);
    end
    ack = 1'b0;
    chk("wr_cs_end", 67'(cs), 67'd0);
    wait_rsp("wr");
    chk("wr_rsp", rcn_out, {1'b1, 1'b0, 1'b1, 6'd9, 2'd1, 4'h3, 20'h04001, 32'hA5A5A5A5});
    step(3);

    // Foreign address passes through unchanged
    w = mk(1, 1, 0, 6'd3, 2'd0, 4'hF, 22'h020000, 32'hCAFEF00D);
    rcn_in = w;
    step(1);
    rcn_in = '0;
    chk("pt_cs_c1", 67'(cs), 67'd0);
    step(1);
    chk("pt_out", rcn_out, w);
    chk("pt_cs_c2", 67'(cs), 67'd0);
    step(3);

    // Back-to-back mine requests, then busy ring during response
    a  = mk(1, 1, 0, 6'd1, 2'd0, 4'hF, 22'h010000, 32'h0);
    b  = mk(1, 1, 0, 6'd2, 2'd3, 4'hF, 22'h010008, 32'h11112222);
    n1 = mk(1, 1, 0, 6'd10, 2'd0, 4'h1, 22'h030000, 32'h01);
    n2 = mk(1, 0, 1, 6'd11, 2'd1, 4'h2, 22'h040000, 32'h02);
    n3 = mk(1, 1, 1, 6'd12, 2'd2, 4'h4, 22'h050000, 32'h03);
    rcn_in = a;
    step(1);
    rcn_in = b;
    step(1);
    chk("b2b_slot0", rcn_out, 67'd0);
    ack = 1'b1; rdata = 32'hFEEDBEEF; rcn_in = n1;
    step(1);
    ack = 1'b0; rcn_in = n2;
    chk("b2b_second", rcn_out, b);
    step(1);
    rcn_in = n3;
    chk("b2b_n1", rcn_out, n1);
    step(1);
    rcn_in = '0;
    chk("b2b_n2", rcn_out, n2);
    step(1);
    chk("b2b_n3", rcn_out, n3);
    step(1);
    chk("b2b_rsp", rcn_out, {1'b1, 1'b0, 1'b0, 6'd1, 2'd0, 4'hF, 20'h04000, 32'hFEEDBEEF});
    step(3);

    // No ack: timeout abort (feature on) or indefinite wait (feature off)
    rcn_in = mk(1, 1, 0, 6'd7, 2'd0, 4'hF, 22'h010020, 32'h0);
    step(1);
    rcn_in = '0;
    step(1);
`ifdef RCN_SLAVE_TIMEOUT_EN
    k = 0;
    while (cs && k < 40) begin
      chk("tmo_nopulse", 67'(timeout), 67'd0);
      step(1);
      k++;
    end
    chk("tmo_len", 67'(k), 67'(TMO));
    chk("tmo_pulse", 67'(timeout), 67'd1);
    step(1);
    chk("tmo_pulse_end", 67'(timeout), 67'd0);
    wait_rsp("tmo");
    chk("tmo_rsp", rcn_out, {1'b1, 1'b0, 1'b0, 6'd7, 2'd0, 4'hF, 20'h04008, 32'hDEADDEAD});
`else
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        chk("wait_cs", 67'(cs), 67'd1);
        chk("wait_timeout", 67'(timeout), 67'd0);
      end
      step(1);
    end
    chk("wait_cs_end", 67'(cs), 67'd1);
    ack = 1'b1; rdata = 32'h0BADF00D;
    step(1);
    ack = 1'b0;
    wait_rsp("wait");
    chk("wait_rsp", rcn_out, {1'b1, 1'b0, 1'b0, 6'd7, 2'd0, 4'hF, 20'h04008, 32'h0BADF00D});
`endif
    step(3);

    // Reset in the middle of a local access drops the request
    rcn_in = mk(1, 1, 1, 6'd4, 2'd1, 4'hC, 22'h01000C, 32'h55AA55AA);
    step(1);
    rcn_in = '0;
    step(2);
    chk("mid_cs_before", 67'(cs), 67'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", 67'(cs), 67'd0);
    chk("mid_rst_out", rcn_out, 67'd0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("mid_no_rsp", 67'(rcn_out[66]), 67'd0);
      chk("mid_no_cs", 67'(cs), 67'd0);
    end

    // Randomized ring traffic with random ack timing
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rcn_in = '0;
        4, 5, 6:    rcn_in = mk(1, 1, 1'($urandom), 6'($urandom), 2'($urandom),
                                4'($urandom), {6'h01, 16'($urandom)}, $urandom);
        7, 8:       rcn_in = mk(1, 1'($urandom), 1'($urandom), 6'($urandom), 2'($urandom),
                                4'($urandom), 22'($urandom), $urandom);
        default:    rcn_in = mk(1, 0, 1'($urandom), 6'($urandom), 2'($urandom),
                                4'($urandom), {6'h01, 16'($urandom)}, $urandom);
      endcase
      ack   = ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      step(1);
    end
    rcn_in = '0;
    ack = 1'b0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
